axis_pkt_gen: RTL and testbench

AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

---
 rtl/axis_pkt_pkg.sv | 20 ++
 rtl/axis_lfsr16.sv | 32 +++
 rtl/axis_pkt_gen.sv | 156 +++++++++++++++
 tb/tb_axis_pkt_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkt_pkg.sv
// Shared types and constants for the AXI-Stream packet generator.
// The LFSR step below implements taps 16,14,13,11 in right-shifting Fibonacci form.
package axis_pkt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
  } state_e;

  localparam int unsigned PKT_ID_WIDTH = 8;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/axis_lfsr16.sv
// Seedable 16-bit Fibonacci LFSR that advances one step per cycle with en high.
// A zero seed is replaced by the package default so the register never locks up.
module axis_lfsr16
  import axis_pkt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        en,
  output logic [15:0] value
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: emits cfg_len beats tagged {pkt_id, beat index} with idle gaps.
// Define AXIS_PKT_GEN_RAND_STALL_EN to allow LFSR-driven random gaps (cfg_rand, cfg_seed).
module axis_pkt_gen
  import axis_pkt_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned TDEST_WIDTH = 4,
  parameter int unsigned LEN_WIDTH   = 8,
  parameter int unsigned GAP_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   cfg_len,
  input  logic [TDEST_WIDTH-1:0] cfg_dest,
  input  logic [GAP_WIDTH-1:0]   cfg_gap,
  input  logic                   cfg_rand,
  input  logic [15:0]            cfg_seed,
  output logic                   busy,
  output logic                   done,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TDEST_WIDTH-1:0] m_axis_tdest,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);

  localparam int unsigned BeatW = TDATA_WIDTH - PKT_ID_WIDTH;

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    beat_q, beat_d;
  logic [TDEST_WIDTH-1:0]  dest_q, dest_d;
  logic [GAP_WIDTH-1:0]    gap_q, gap_d;
  logic [GAP_WIDTH-1:0]    gap_cnt_q, gap_cnt_d;
  logic [PKT_ID_WIDTH-1:0] pkt_id_q, pkt_id_d;
  logic                    done_q, done_d;
  logic                    accept;
  logic                    last_beat;
  logic                    start_ok;
  logic [GAP_WIDTH-1:0]    gap_sel;
  logic [BeatW-1:0]        beat_ext;

  assign start_ok  = (state_q == StIdle) && start && (cfg_len != '0);
  assign accept    = (state_q == StSend) && m_axis_tready;
  assign last_beat = (beat_q == len_q - LEN_WIDTH'(1));

`ifdef AXIS_PKT_GEN_RAND_STALL_EN
  logic        rand_q, rand_d;
  logic [15:0] lfsr_value;
  logic        unused_lfsr;

  axis_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (cfg_seed),
    .en    (accept),
    .value (lfsr_value)
  );

  assign unused_lfsr = ^lfsr_value;
  assign rand_d      = start_ok ? cfg_rand : rand_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rand_q <= 1'b0;
    end else begin
      rand_q <= rand_d;
    end
  end

  // Gap comes from the LFSR value present in the accepting cycle, before it advances.
  assign gap_sel = rand_q ? lfsr_value[GAP_WIDTH-1:0] : gap_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_rand, cfg_seed};
  assign gap_sel    = gap_q;
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    beat_d    = beat_q;
    dest_d    = dest_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    pkt_id_d  = pkt_id_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          len_d   = cfg_len;
          dest_d  = cfg_dest;
          gap_d   = cfg_gap;
          beat_d  = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (accept) begin
          if (last_beat) begin
            state_d  = StIdle;
            done_d   = 1'b1;
            pkt_id_d = pkt_id_q + PKT_ID_WIDTH'(1);
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
            if (gap_sel != '0) begin
              gap_cnt_d = gap_sel - GAP_WIDTH'(1);
              state_d   = StGap;
            end
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StSend;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      beat_q    <= '0;
      dest_q    <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      pkt_id_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      dest_q    <= dest_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      pkt_id_q  <= pkt_id_d;
      done_q    <= done_d;
    end
  end

  // All stream outputs derive from registered state, so they hold while stalled.
  assign beat_ext      = BeatW'(beat_q);
  assign m_axis_tvalid = (state_q == StSend);
  assign m_axis_tlast  = (state_q == StSend) && last_beat;
  assign m_axis_tdata  = {pkt_id_q, beat_ext};
  assign m_axis_tdest  = dest_q;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: directed scenarios plus randomized packets
// checked cycle by cycle against a beat/gap reference model.
module tb_axis_pkt_gen;

  localparam int TDW = 32;
  localparam int DW  = 4;
  localparam int LW  = 8;
  localparam int GW  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [LW-1:0]  cfg_len = '0;
  logic [DW-1:0]  cfg_dest = '0;
  logic [GW-1:0]  cfg_gap = '0;
  logic           cfg_rand = 1'b0;
  logic [15:0]    cfg_seed = 16'h0;
  logic           busy, done;
  logic [TDW-1:0] m_axis_tdata;
  logic [DW-1:0]  m_axis_tdest;
  logic           m_axis_tlast, m_axis_tvalid;
  logic           m_axis_tready = 1'b0;

  int        n_checks = 0;
  int        n_errors = 0;
  logic [7:0] pkt_id_m = 8'h00;
  int        lfsr_m = 'hACE1;

  axis_pkt_gen #(
    .TDATA_WIDTH (TDW),
    .TDEST_WIDTH (DW),
    .LEN_WIDTH   (LW),
    .GAP_WIDTH   (GW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_len       (cfg_len),
    .cfg_dest      (cfg_dest),
    .cfg_gap       (cfg_gap),
    .cfg_rand      (cfg_rand),
    .cfg_seed      (cfg_seed),
    .busy          (busy),
    .done          (done),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tdest  (m_axis_tdest),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference LFSR: new MSB is the parity of bits 0,2,3,5 (taps 16,14,13,11).
  function automatic int lfsr_step(input int v);
    int fb;
    fb = $countones(v & 'h2D) & 1;
    return ((v >> 1) | (fb << 15)) & 'hFFFF;
  endfunction

  task automatic do_reset(input logic [15:0] seed);
    cfg_seed = seed;
    start    = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_tvalid", m_axis_tvalid, 0);
    check_eq("rst_tlast", m_axis_tlast, 0);
    check_eq("rst_tdata", m_axis_tdata, 0);
    check_eq("rst_tdest", m_axis_tdest, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    pkt_id_m = 8'h00;
    lfsr_m   = (seed == 16'h0) ? 'hACE1 : int'(seed);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("idle_tvalid", m_axis_tvalid, 0);
      check_eq("idle_busy", busy, 0);
    end
  endtask

  // Called on a negedge; returns on the negedge of the done cycle (or after a reset abort).
  // ready_mode: 0 always ready, 1 alternating 1010..., 2 random.
  task automatic send_pkt(input int len, input int dest, input int gap, input bit rnd,
                          input int ready_mode, input int abort_k, input bit busy_start);
    int k = 0;
    int idle = 0;
    int cyc = 0;
    int nacc = 0;
    int gsel;
    bit fin = 0;
    bit ex_valid;
    bit rdy;
    start    = 1'b1;
    cfg_len  = LW'(len);
    cfg_dest = DW'(dest);
    cfg_gap  = GW'(gap);
    cfg_rand = rnd;
    @(negedge clk);
    start    = 1'b0;
    cfg_len  = LW'($urandom);
    cfg_dest = DW'($urandom);
    cfg_gap  = GW'($urandom);
    cfg_rand = 1'($urandom);
    while (!fin) begin
      if (cyc >= 600) begin
        check_eq("pkt_timeout", nacc, len);
        return;
      end
      ex_valid = (idle == 0);
      check_eq("tvalid", m_axis_tvalid, ex_valid);
      check_eq("busy", busy, 1);
      check_eq("done_early", done, 0);
      if (ex_valid) begin
        check_eq("tdata", m_axis_tdata, (longint'(pkt_id_m) << (TDW - 8)) | longint'(k));
        check_eq("tlast", m_axis_tlast, (k == len - 1));
        check_eq("tdest", m_axis_tdest, dest);
      end else begin
        idle--;
      end
      if (abort_k >= 0 && ex_valid && k == abort_k) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_tvalid", m_axis_tvalid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_tdata", m_axis_tdata, 0);
        pkt_id_m = 8'h00;
        lfsr_m   = (cfg_seed == 16'h0) ? 'hACE1 : int'(cfg_seed);
        return;
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      m_axis_tready = rdy;
      if (busy_start && cyc == 1) begin
        start   = 1'b1;
        cfg_len = LW'(2);
      end else begin
        start = 1'b0;
      end
      if (ex_valid && rdy) begin
        nacc++;
        gsel = gap;
`ifdef AXIS_PKT_GEN_RAND_STALL_EN
        if (rnd) gsel = lfsr_m % (1 << GW);
`endif
        lfsr_m = lfsr_step(lfsr_m);
        if (k == len - 1) fin = 1;
        else begin
          k++;
          idle = gsel;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_eq("handshakes", nacc, len);
    check_eq("done_pulse", done, 1);
    check_eq("done_busy", busy, 0);
    check_eq("done_tvalid", m_axis_tvalid, 0);
    pkt_id_m = pkt_id_m + 8'h01;
  endtask

  initial begin
    @(negedge clk);
    do_reset(16'h0000);
    idle_cycles(2);

    // Back-to-back beats; then gapped packets, the second started in the done cycle.
    send_pkt(4, 3, 0, 1'b0, 0, -1, 1'b0);
    idle_cycles(1);
    send_pkt(3, 1, 2, 1'b0, 0, -1, 1'b0);
    send_pkt(3, 2, 2, 1'b0, 0, -1, 1'b0);
    idle_cycles(1);

    // Stalls must hold data steady.
    send_pkt(5, 7, 0, 1'b0, 1, -1, 1'b0);
    idle_cycles(1);

    // Zero-length start is ignored; start while busy is ignored.
    start   = 1'b1;
    cfg_len = '0;
    idle_cycles(4);
    start = 1'b0;
    send_pkt(4, 9, 1, 1'b0, 0, -1, 1'b1);
    idle_cycles(2);

    // Reset mid-packet abandons it and clears pkt_id.
    send_pkt(8, 4, 0, 1'b0, 0, 2, 1'b0);
    idle_cycles(1);
    send_pkt(2, 6, 0, 1'b0, 0, -1, 1'b0);
    idle_cycles(1);

    for (int p = 0; p < 10; p++) begin
      send_pkt($urandom_range(1, 6), $urandom_range(0, 15), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 2, -1, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(1);

    // Seeded random gaps.
    do_reset(16'h0001);
    send_pkt(6, 5, 0, 1'b1, 0, -1, 1'b0);
    idle_cycles(1);
    send_pkt(6, 2, 1, 1'b1, 2, -1, 1'b0);
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
